// File: rtl/laser_pkg.sv
// laser_pkg: constants, state encoding and segment-request field widths shared by the laser
// sequencer and the segment drawer.
//   SCREEN_W / LASER_W : screen width and laser segment width in pixels
//   Y_START / Y_TOP    : launch row and last row drawn before retirement
//   STEP_DIV           : frame ticks per one-row step (>= 1)
//   clamp_x()          : keeps a launched segment fully on screen
package laser_pkg;

  localparam int unsigned SCREEN_W = 160;
  localparam int unsigned LASER_W  = 5;
  localparam int unsigned SEG_X_W  = 8;
  localparam int unsigned SEG_Y_W  = 7;
  localparam int unsigned STEP_DIV = 2;

  localparam logic [SEG_Y_W-1:0] Y_START = 7'd110;
  localparam logic [SEG_Y_W-1:0] Y_TOP   = 7'd0;
  localparam logic [SEG_X_W-1:0] X_MAX   = SEG_X_W'(SCREEN_W - LASER_W);

  typedef enum logic [2:0] {
    StIdle,
    StDraw,
    StDrawWait,
    StFly,
    StErase,
    StEraseWait
  } laser_state_e;

  function automatic logic [SEG_X_W-1:0] clamp_x(input logic [SEG_X_W-1:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

endpackage

// File: rtl/laser_ctrl_if.sv
// laser_ctrl_if: segment request/handshake between the laser sequencer and the drawer.
//   seg_start : one-cycle request (master -> slave)
//   seg_x     : segment left-edge x (master -> slave)
//   seg_y     : segment row (master -> slave)
//   seg_erase : 1 = background colour, 0 = laser colour (master -> slave)
//   seg_done  : drawer finished the requested segment (slave -> master)
interface laser_ctrl_if;
  import laser_pkg::*;

  logic               seg_start;
  logic [SEG_X_W-1:0] seg_x;
  logic [SEG_Y_W-1:0] seg_y;
  logic               seg_erase;
  logic               seg_done;

  modport master (
    output seg_start,
    output seg_x,
    output seg_y,
    output seg_erase,
    input  seg_done
  );

  modport slave (
    input  seg_start,
    input  seg_x,
    input  seg_y,
    input  seg_erase,
    output seg_done
  );

endinterface

// File: rtl/laser_ctrl_rise_det.sv
// rise_det: single-flop rising-edge detector.
//   clk    : system clock
//   rst    : asynchronous active-high reset (history cleared to 0)
//   d_i    : level input, already synchronous to clk
//   rise_o : high in the cycle where d_i is 1 and was 0 in the previous cycle
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic rise_o
);

  logic d_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d_i;
    end
  end

  assign rise_o = d_i & ~d_q;

endmodule

// File: rtl/laser_ctrl.sv
// laser_ctrl: sequencer for the single player laser. Launches from the ship on space, steps one
// row up every STEP_DIV frame ticks, requesting an erase at the old row and a draw at the new
// one, and retires the laser at Y_TOP or after a hit.
//   clk, rst     : clock, asynchronous active-high reset
//   space_i      : space-bar level (synchronised)
//   ship_x_i     : ship left-edge x
//   frame_tick_i : one-cycle pulse per video frame
//   hit_i        : one-cycle collision pulse
//   seg_if       : segment request/handshake (master side)
//   active_o     : laser in flight
//   fired_o      : one-cycle pulse on launch
// Build option: LASER_AUTOFIRE_EN makes launch level-triggered on space_i, so a held key re-fires
// as soon as the previous laser retires; otherwise a fresh rising edge is required.
module laser_ctrl
  import laser_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               space_i,
  input  logic [SEG_X_W-1:0] ship_x_i,
  input  logic               frame_tick_i,
  input  logic               hit_i,
  laser_ctrl_if.master       seg_if,
  output logic               active_o,
  output logic               fired_o
);

  localparam int unsigned   CntW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(STEP_DIV - 1);

  laser_state_e       state_q, state_d;
  logic [SEG_X_W-1:0] x_q, x_d;
  logic [SEG_Y_W-1:0] y_q, y_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               hit_q, hit_d;
  logic               fired_q, fired_d;
  logic               launch;

`ifdef LASER_AUTOFIRE_EN
  assign launch = space_i;
`else
  logic space_rise;

  rise_det u_rise_det (
    .clk    (clk),
    .rst    (rst),
    .d_i    (space_i),
    .rise_o (space_rise)
  );

  assign launch = space_rise;
`endif

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    hit_d   = hit_q;
    fired_d = 1'b0;

    // Sticky until the next launch; a hit while idle has no laser to hit.
    if (state_q != StIdle && hit_i) begin
      hit_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        if (launch) begin
          x_d     = clamp_x(ship_x_i);
          y_d     = Y_START;
          cnt_d   = '0;
          hit_d   = 1'b0;
          fired_d = 1'b1;
          state_d = StDraw;
        end
      end
      StDraw: state_d = StDrawWait;
      StDrawWait: begin
        if (seg_if.seg_done) begin
          state_d = StFly;
        end
      end
      StFly: begin
        if (hit_q) begin
          cnt_d   = '0;
          state_d = StErase;
        end else if (frame_tick_i) begin
          if (cnt_q == CntLast) begin
            cnt_d   = '0;
            state_d = StErase;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      StErase: state_d = StEraseWait;
      StEraseWait: begin
        if (seg_if.seg_done) begin
          // Top-row check comes first so y never wraps below Y_TOP.
          if (hit_q || y_q == Y_TOP) begin
            state_d = StIdle;
          end else begin
            y_d     = y_q - SEG_Y_W'(1);
            state_d = StDraw;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      x_q     <= '0;
      y_q     <= Y_START;
      cnt_q   <= '0;
      hit_q   <= 1'b0;
      fired_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cnt_q   <= cnt_d;
      hit_q   <= hit_d;
      fired_q <= fired_d;
    end
  end

  // Moore outputs: erase stays high through the wait so the request is stable until acked.
  assign seg_if.seg_start = (state_q == StDraw) || (state_q == StErase);
  assign seg_if.seg_erase = (state_q == StErase) || (state_q == StEraseWait);
  assign seg_if.seg_x     = x_q;
  assign seg_if.seg_y     = y_q;
  assign active_o         = (state_q != StIdle);
  assign fired_o          = fired_q;

endmodule

// File: tb/tb_laser_ctrl.sv
// tb_laser_ctrl: self-checking bench for laser_ctrl. A drawer model acks each segment request
// after a random delay and logs it; each flight is compared against the row sequence expected
// from launch position and retirement row. Honours LASER_AUTOFIRE_EN like the design.
`timescale 1ns/1ps
module tb_laser_ctrl;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic       erase;
  } req_t;

  logic       clk;
  logic       rst;
  logic       space;
  logic [7:0] ship_x;
  logic       hit;
  logic       tick_gen;
  logic       tick_man;
  logic       tick_en;
  int         tick_per;
  logic       active;
  logic       fired;
  wire        frame_tick = tick_gen | tick_man;

  req_t req_q[$];
  int   n_assert;
  int   n_fail;
  int   fired_cnt;
  int   fired_base;
  int   epoch;

  laser_ctrl_if seg_if ();

  laser_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .space_i      (space),
    .ship_x_i     (ship_x),
    .frame_tick_i (frame_tick),
    .hit_i        (hit),
    .seg_if       (seg_if),
    .active_o     (active),
    .fired_o      (fired)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Frame tick generator: one pulse every tick_per cycles while enabled.
  initial begin
    int c;
    c = 0;
    tick_gen = 1'b0;
    forever begin
      @(negedge clk);
      if (tick_en) begin
        c++;
        if (c >= tick_per) begin
          tick_gen = 1'b1;
          c = 0;
        end else begin
          tick_gen = 1'b0;
        end
      end else begin
        tick_gen = 1'b0;
        c = 0;
      end
    end
  end

  initial begin
    fired_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (fired === 1'b1) fired_cnt++;
    end
  end

  // Drawer model: log each request, hold off a random 2..6 cycles, check the request stayed
  // stable, then ack for one cycle.
  initial begin
    req_t cur;
    int   dly;
    int   ep;
    seg_if.seg_done = 1'b0;
    @(posedge clk);
    #1;
    forever begin
      if (seg_if.seg_start === 1'b1) begin
        cur = '{x: seg_if.seg_x, y: seg_if.seg_y, erase: seg_if.seg_erase};
        req_q.push_back(cur);
        ep  = epoch;
        dly = $urandom_range(6, 2);
        repeat (dly) @(negedge clk);
        if (ep == epoch) begin
          check("seg_hold", 32'({seg_if.seg_x, seg_if.seg_y, seg_if.seg_erase}), 32'(cur));
        end
        seg_if.seg_done = 1'b1;
        @(posedge clk);
        #1;
        seg_if.seg_done = 1'b0;
      end else begin
        @(posedge clk);
        #1;
      end
    end
  end

  function automatic logic [7:0] exp_x(input logic [7:0] sx);
    return (sx > 8'd155) ? 8'd155 : sx;
  endfunction

  // Returns at one time unit after the launch edge, with the laser in its first draw cycle.
  task automatic launch(input logic [7:0] sx, input bit hold);
    repeat (2) @(negedge clk);
    req_q.delete();
    fired_base = fired_cnt;
    ship_x = sx;
    space  = 1'b1;
    @(posedge clk);
    #1;
    check("launch_fired", 32'(fired), 1);
    check("launch_start", 32'(seg_if.seg_start), 1);
    check("launch_x", 32'(seg_if.seg_x), 32'(exp_x(sx)));
    check("launch_y", 32'(seg_if.seg_y), 110);
    check("launch_erase", 32'(seg_if.seg_erase), 0);
    check("launch_active", 32'(active), 1);
    if (!hold) begin
      @(negedge clk);
      space = 1'b0;
    end
  endtask

  task automatic wait_idle(input string tag);
    int i;
    i = 0;
    while (active !== 1'b0 && i < 20000) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(tag, 32'(i < 20000), 1);
  endtask

  task automatic wait_req(input logic [6:0] y, input logic er, input string tag);
    int i;
    i = 0;
    while (!(seg_if.seg_start === 1'b1 && seg_if.seg_y === y && seg_if.seg_erase === er)
           && i < 20000) begin
      @(posedge clk);
      #1;
      i++;
    end
    check(tag, 32'(i < 20000), 1);
  endtask

  // Returns on the negedge where the draw ack is presented; the laser is in flight after the
  // following posedge.
  task automatic wait_ack(input string tag);
    int i;
    i = 0;
    while (seg_if.seg_done !== 1'b1 && i < 100) begin
      @(negedge clk);
      #1;
      i++;
    end
    check(tag, 32'(i < 100), 1);
  endtask

  // Hit pulse landing while the drawer is still busy with the draw at this row.
  task automatic hit_at_draw(input logic [6:0] row);
    wait_req(row, 1'b0, "hit_row_seen");
    @(posedge clk);
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;
  endtask

  // A flight from row 110 retiring at y_stop draws then erases every row in turn.
  task automatic compare_flight(input string tag, input logic [7:0] sx, input int y_stop);
    req_t exp_q[$];
    req_t e;
    for (int y = 110; y >= y_stop; y--) begin
      e = '{x: exp_x(sx), y: 7'(y), erase: 1'b0};
      exp_q.push_back(e);
      e.erase = 1'b1;
      exp_q.push_back(e);
    end
    check({tag, "_len"}, 32'(req_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
      check($sformatf("%s_req%0d", tag, i), 32'(req_q[i]), 32'(exp_q[i]));
      if (req_q[i] !== exp_q[i]) break;
    end
  endtask

  initial begin
    logic [7:0] sx;
    int         row;
    int         sz;
    n_assert = 0;
    n_fail   = 0;
    epoch    = 0;
    rst      = 1'b1;
    space    = 1'b0;
    ship_x   = 8'd0;
    hit      = 1'b0;
    tick_man = 1'b0;
    tick_en  = 1'b0;
    tick_per = 3;

    repeat (3) @(posedge clk);
    #1;
    check("rst_start", 32'(seg_if.seg_start), 0);
    check("rst_erase", 32'(seg_if.seg_erase), 0);
    check("rst_x", 32'(seg_if.seg_x), 0);
    check("rst_y", 32'(seg_if.seg_y), 110);
    check("rst_active", 32'(active), 0);
    check("rst_fired", 32'(fired), 0);
    @(negedge clk);
    rst = 1'b0;

    // Hit while idle must not cut the next flight short.
    @(negedge clk);
    hit = 1'b1;
    @(negedge clk);
    hit = 1'b0;

    // Full flight to the top row.
    tick_en  = 1'b1;
    tick_per = $urandom_range(4, 1);
    launch(8'd40, 1'b0);
    wait_idle("full_retire");
    check("full_fired_once", 32'(fired_cnt - fired_base), 1);
    compare_flight("full", 8'd40, 0);
    check("full_start_low", 32'(seg_if.seg_start), 0);

    // Clamped launch, space held and toggled in flight, hit during the draw at row 80.
    launch(8'd158, 1'b1);
    repeat (8) begin
      repeat ($urandom_range(9, 3)) @(negedge clk);
      space = ~space;
    end
    hit_at_draw(7'd80);
    wait_idle("hit80_retire");
    check("hit80_fired_once", 32'(fired_cnt - fired_base), 1);
    compare_flight("hit80", 8'd158, 80);

    // Space still held after retirement.
    repeat (20) @(posedge clk);
    #1;
`ifdef LASER_AUTOFIRE_EN
    check("autofire_active", 32'(active), 1);
    check("autofire_refired", 32'(fired_cnt - fired_base), 2);
    @(negedge clk);
    space = 1'b0;
    hit   = 1'b1;
    @(negedge clk);
    hit   = 1'b0;
    wait_idle("autofire_retire");
`else
    check("hold_no_refire_active", 32'(active), 0);
    check("hold_no_refire_fired", 32'(fired_cnt - fired_base), 1);
`endif
    @(negedge clk);
    space = 1'b0;

    // One tick must not step; the second one must.
    tick_en = 1'b0;
    launch(8'd12, 1'b0);
    wait_ack("step_ack");
    @(negedge clk);
    tick_man = 1'b1;
    @(negedge clk);
    tick_man = 1'b0;
    repeat (5) @(negedge clk);
    check("one_tick_no_step", 32'(req_q.size()), 1);
    tick_man = 1'b1;
    @(negedge clk);
    tick_man = 1'b0;
    @(negedge clk);
    #1;
    check("two_tick_step", 32'(req_q.size()), 2);
    hit_at_draw(7'd109);
    wait_idle("step_retire");
    compare_flight("step", 8'd12, 109);

    // Tick and hit in the same cycle: single erase, then retire.
    sx = 8'($urandom_range(255, 0));
    launch(sx, 1'b0);
    wait_ack("tickhit_ack");
    @(negedge clk);
    tick_man = 1'b1;
    hit      = 1'b1;
    @(negedge clk);
    tick_man = 1'b0;
    hit      = 1'b0;
    wait_idle("tickhit_retire");
    compare_flight("tickhit", sx, 110);

    // Random launch positions and hit rows.
    tick_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sx       = 8'($urandom_range(255, 0));
      row      = $urandom_range(109, 100);
      tick_per = $urandom_range(4, 1);
      launch(sx, 1'b0);
      hit_at_draw(7'(row));
      wait_idle("rand_retire");
      compare_flight($sformatf("rand%0d", k), sx, row);
    end

    // Reset while waiting for an erase ack.
    launch(8'd77, 1'b0);
    wait_req(7'd110, 1'b1, "erase_seen");
    @(posedge clk);
    #2;
    epoch++;
    rst = 1'b1;
    #1;
    check("mid_rst_start", 32'(seg_if.seg_start), 0);
    check("mid_rst_erase", 32'(seg_if.seg_erase), 0);
    check("mid_rst_x", 32'(seg_if.seg_x), 0);
    check("mid_rst_y", 32'(seg_if.seg_y), 110);
    check("mid_rst_active", 32'(active), 0);
    check("mid_rst_fired", 32'(fired), 0);
    @(negedge clk);
    rst = 1'b0;
    fired_base = fired_cnt;
    sz = req_q.size();
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_no_req", 32'(req_q.size()), 32'(sz));
    check("post_rst_no_fire", 32'(fired_cnt - fired_base), 0);
    check("post_rst_idle", 32'(active), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/laser_ctrl.md
# laser_ctrl

Upstream sequencer for the 5-pixel laser segment drawer. Owns the single player laser: launches it from the ship on a space-bar press, advances it one row up the screen every STEP_DIV frames, and on each step requests an erase at the old row and a draw at the new one. The laser is retired when it reaches the top row or a hit is reported. The segment drawer consumes `seg_*` and reports completion on `seg_done`.

## Interface
- `SCREEN_W`, 160, screen width in pixels
- `LASER_W`, 5, laser segment width in pixels
- `Y_START`, 7'd110, launch row (row above the ship)
- `Y_TOP`, 7'd0, last row drawn before retirement
- `STEP_DIV`, 2, frame ticks per one-row step (≥1)

- `clk`  in  1  system clock
- `reset`  in  1  asynchronous, active-high reset
- `space`  in  1  space-bar level, already synchronised to `clk`
- `ship_x`  in  8  ship left-edge x coordinate
- `frame_tick`  in  1  one-cycle pulse per video frame
- `hit`  in  1  one-cycle collision pulse from invader logic
- `seg_done`  in  1  drawer finished the requested segment
- `seg_start`  out  1  one-cycle request to draw/erase a segment
- `seg_x`  out  8  segment left-edge x
- `seg_y`  out  7  segment row
- `seg_erase`  out  1  1 = paint background, 0 = paint laser colour
- `active`  out  1  laser in flight
- `fired`  out  1  one-cycle pulse on launch

## Operation
- FSM states: IDLE, DRAW, DRAW_WAIT, FLY, ERASE, ERASE_WAIT.
- IDLE: on `space` rising edge → latch `x = min(ship_x, SCREEN_W-LASER_W)` (155 by default), `y = Y_START`, pulse `fired`, clear hit flag, go to DRAW.
- DRAW: `seg_start=1`, `seg_erase=0` for one cycle → DRAW_WAIT.
- DRAW_WAIT: hold until `seg_done` → FLY.
- FLY: count `frame_tick`; when count reaches STEP_DIV-1 on a tick, or hit flag set → ERASE; counter cleared on exit.
- ERASE: `seg_start=1`, `seg_erase=1` for one cycle → ERASE_WAIT.
- ERASE_WAIT: on `seg_done`: if hit flag set or `y == Y_TOP` → IDLE; else `y <= y-1` → DRAW.
- Hit flag: set by `hit` in any non-IDLE state, sticky until the next launch; `hit` in IDLE ignored.
- `space` edges while `active` are discarded (one laser at a time); no queuing.
- `active` = 1 in every state except IDLE.
- `y` decrement never underflows: Y_TOP check precedes decrement.

## Timing
- Reset values: state IDLE, `seg_start=0`, `seg_erase=0`, `seg_x=0`, `seg_y=Y_START`, `active=0`, `fired=0`, frame counter 0, hit flag 0, edge-detector history 0.
- All outputs registered or decoded from registered state only (Moore); no input-to-output combinational path.
- Launch latency: `space` rises in cycle N → `fired` and entry to DRAW in N+1, `seg_start` high in N+1.
- `seg_x`, `seg_y`, `seg_erase` valid in the `seg_start` cycle and stable until `seg_done` is accepted.
- `seg_done` sampled only in DRAW_WAIT/ERASE_WAIT; ignored elsewhere, including the `seg_start` cycle.
- `frame_tick` and `hit` in the same cycle in FLY: leave FLY once (to ERASE), laser retired after erase.
- `frame_tick` outside FLY ignored (step slips, not accumulated).
- Reset mid-flight: immediate return to IDLE; the segment on screen is not erased (the frame clear owns that).

## Configuration
- `LASER_AUTOFIRE_EN` defined: in IDLE, `space` held high launches (level-triggered), so holding the key re-fires as soon as the previous laser retires.
- Undefined: launch needs a fresh rising edge of `space`; holding the key fires exactly once.

## Structure
- `laser_pkg`: state enum, `LASER_W`, screen-size constants, segment-request field widths; shared with the segment drawer.
- One sub-module: `rise_det` (single-flop rising-edge detector on `space`); bypassed for launch decision under `LASER_AUTOFIRE_EN`.

## Test plan
- Reset, `space` pulse with `ship_x=40` → `fired` next cycle, `seg_start` with x=40, y=110, erase=0.
- `ship_x=158` launch → `seg_x=155`.
- STEP_DIV=2, drawer acks after 5 cycles, 2 frame ticks → erase at y=110 then draw at y=109; flight to Y_TOP ends with erase at y=0, `active=0`.
- `hit` during DRAW_WAIT at y=80 → after draw ack, one erase at y=80, then IDLE; no draw at 79.
- `space` toggled during flight → no extra `fired`; held high after retirement → relaunch only with `LASER_AUTOFIRE_EN`.
- `reset` asserted in ERASE_WAIT → all outputs at reset values same cycle; no `seg_start` until next launch.
